// File: rtl/sprite_pkg.sv
// Shared sprite geometry, digit encodings and arbiter state type for the
// digit sprite ROM bank.
package sprite_pkg;

  localparam int unsigned SPRITE_W = 20;
  localparam int unsigned SPRITE_H = 20;
  localparam int unsigned DEPTH    = SPRITE_W * SPRITE_H;

  localparam logic [7:0] TRANSPARENT_PX = 8'h00;

  typedef enum logic [3:0] {
    DIGIT_0 = 4'd0,
    DIGIT_1 = 4'd1,
    DIGIT_2 = 4'd2,
    DIGIT_3 = 4'd3,
    DIGIT_4 = 4'd4,
    DIGIT_5 = 4'd5,
    DIGIT_6 = 4'd6,
    DIGIT_7 = 4'd7,
    DIGIT_8 = 4'd8,
    DIGIT_9 = 4'd9
  } digit_e;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible request at or cyclically
// after the pointer, with an exclude mask applied first.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic [NREQ-1:0] excl,
  output logic [NREQ-1:0] win_c,
  output logic [PW-1:0]   idx_c,
  output logic            any_c
);

  logic [NREQ-1:0] cand;

  always_comb begin
    int unsigned j;
    j     = 0;
    cand  = req & ~excl;
    win_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any_c && cand[PW'(j)]) begin
        any_c           = 1'b1;
        idx_c           = PW'(j);
        win_c[PW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with locked bursts sharing the digit sprite ROM bank;
// tracks the one-cycle ROM latency and steers each pixel back to its requester.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 8,
  parameter int unsigned SELW      = 4,
  parameter int unsigned DEPTH     = 400,
  parameter int unsigned MAX_BURST = 20
) (
  input  logic                 i_clk2,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_lock,
  input  logic [NREQ*AW-1:0]   i_addr,
  input  logic [NREQ*SELW-1:0] i_sel,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_rvalid,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_rom_en,
  output logic [AW-1:0]        o_rom_addr,
  output logic [SELW-1:0]      o_rom_sel,
  input  logic [DW-1:0]        i_rom_data
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, win_idx, pick_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_d, excl, pick_win, owner_oh;
  logic            pick_any, issue, burst_go, cap_hit;
  logic            oor_q, rv_oor_q;
  logic [AW-1:0]   addr_a [NREQ];
  logic [SELW-1:0] sel_a  [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_a[k] = i_addr[k*AW +: AW];
    assign sel_a[k]  = i_sel[k*SELW +: SELW];
  end

  assign owner_oh = NREQ'(1) << owner_q;
  assign burst_go = (state_q == ST_BURST) && i_req[owner_q] && i_lock[owner_q]
                    && (32'(cnt_q) < MAX_BURST);
  assign cap_hit  = (state_q == ST_BURST) && (32'(cnt_q) >= MAX_BURST);
  // Owner sits out after a full burst only when someone else is waiting.
  assign excl     = (cap_hit && |(i_req & ~owner_oh)) ? owner_oh : '0;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .excl  (excl),
    .win_c (pick_win),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  // Next-state, pointer and grant selection
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    win_idx = pick_idx;
    issue   = 1'b0;
    if (burst_go) begin
      issue   = 1'b1;
      win_idx = owner_q;
      gnt_d   = owner_oh;
      cnt_d   = cnt_q + CW'(1);
    end else if (pick_any) begin
      issue = 1'b1;
      gnt_d = pick_win;
      ptr_d = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + PW'(1);
      if (i_lock[pick_idx]) begin
        state_d = ST_BURST;
        owner_d = pick_idx;
        cnt_d   = CW'(1);
      end else begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end
    end else begin
      state_d = ST_ARB;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      o_gnt      <= '0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
      o_rom_sel  <= '0;
      oor_q      <= 1'b0;
      o_rvalid   <= '0;
      rv_oor_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      o_gnt    <= gnt_d;
      o_rom_en <= issue;
      if (issue) begin
        o_rom_addr <= addr_a[win_idx];
        o_rom_sel  <= sel_a[win_idx];
      end
      oor_q    <= issue && (32'(addr_a[win_idx]) >= DEPTH);
      o_rvalid <= o_gnt;
      rv_oor_q <= oor_q;
    end
  end

  assign o_rdata = !(|o_rvalid) ? '0 :
                   rv_oor_q     ? DW'(TRANSPARENT_PX) : i_rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed request patterns push
// expected grants and pixels; a negedge monitor pops and compares them.
module tb_sprite_rom_arbiter;

  logic        i_clk2 = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_req, i_lock;
  logic [39:0] i_addr;
  logic [15:0] i_sel;
  logic [3:0]  o_gnt, o_rvalid;
  logic [7:0]  o_rdata;
  logic        o_rom_en;
  logic [9:0]  o_rom_addr;
  logic [3:0]  o_rom_sel;
  logic [7:0]  i_rom_data = 8'h00;

  logic [9:0]  addr_v [4];
  logic [3:0]  sel_v  [4];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {int cyc; logic [3:0] gnt; logic [9:0] addr; logic [3:0] sel;} gexp_t;
  typedef struct {int cyc; logic [3:0] rv; logic [7:0] data;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  assign i_addr = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};
  assign i_sel  = {sel_v[3], sel_v[2], sel_v[1], sel_v[0]};

  sprite_rom_arbiter dut (
    .i_clk2     (i_clk2),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_lock     (i_lock),
    .i_addr     (i_addr),
    .i_sel      (i_sel),
    .o_gnt      (o_gnt),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .o_rom_en   (o_rom_en),
    .o_rom_addr (o_rom_addr),
    .o_rom_sel  (o_rom_sel),
    .i_rom_data (i_rom_data)
  );

  always #5 i_clk2 = ~i_clk2;
  always @(posedge i_clk2) cyc <= cyc + 1;

  function automatic logic [7:0] rom_f(input logic [3:0] s, input logic [9:0] a);
    return 8'(32'(a) * 7 + 32'(s) * 31 + 1);
  endfunction

  // Synchronous ROM: data appears one edge after the address.
  always @(posedge i_clk2) if (o_rom_en) i_rom_data <= rom_f(o_rom_sel, o_rom_addr);

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0h, required %0h", nm, cyc, act, exp);
    end
  endfunction

  task automatic issue(input logic [3:0] req, input logic [3:0] lock, input logic [3:0] exp_g,
                       input int k = -1, input logic [9:0] a = '0, input logic [3:0] s = '0,
                       input bit want_rd = 1'b1);
    int idx;
    @(negedge i_clk2);
    if (k >= 0) begin
      addr_v[k] = a;
      sel_v[k]  = s;
    end
    i_req  = req;
    i_lock = lock;
    idx = 0;
    for (int j = 0; j < 4; j++) if (exp_g[j]) idx = j;
    gq.push_back(gexp_t'{cyc + 1, exp_g, addr_v[idx], sel_v[idx]});
    if (exp_g != 4'b0 && want_rd)
      rq.push_back(rexp_t'{cyc + 2, exp_g,
                           (addr_v[idx] >= 10'd400) ? 8'h00 : rom_f(sel_v[idx], addr_v[idx])});
  endtask

  // Monitor
  always @(negedge i_clk2) begin
    gexp_t g;
    rexp_t r;
    if (gq.size() != 0 && gq[0].cyc == cyc) begin
      g = gq.pop_front();
      chk("gnt", 32'(o_gnt), 32'(g.gnt));
      if (g.gnt != 4'b0) begin
        chk("rom_en", 32'(o_rom_en), 32'd1);
        chk("rom_addr", 32'(o_rom_addr), 32'(g.addr));
        chk("rom_sel", 32'(o_rom_sel), 32'(g.sel));
      end else begin
        chk("rom_en_idle", 32'(o_rom_en), 32'd0);
      end
    end else if (o_gnt != 4'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_gnt (cycle %0d): got %0h, required 0", cyc, o_gnt);
    end
    if (rq.size() != 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      chk("rvalid", 32'(o_rvalid), 32'(r.rv));
      chk("rdata", 32'(o_rdata), 32'(r.data));
    end else if (o_rvalid != 4'b0 || o_rdata != 8'h00) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_rvalid (cycle %0d): got rvalid %0h rdata %0h, required 0", cyc, o_rvalid, o_rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_req  = 4'b0;
    i_lock = 4'b0;
    for (int k = 0; k < 4; k++) begin
      addr_v[k] = '0;
      sel_v[k]  = '0;
    end
    #12;
    chk("rst_gnt", 32'(o_gnt), 32'd0);
    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
    chk("rst_rom_en", 32'(o_rom_en), 32'd0);
    chk("rst_rom_addr", 32'(o_rom_addr), 32'd0);
    chk("rst_rom_sel", 32'(o_rom_sel), 32'd0);
    chk("rst_rdata", 32'(o_rdata), 32'd0);
    @(negedge i_clk2);
    i_rst_n = 1'b1;

    // Single request: requester 0, addr 5, digit 3
    issue(4'b0001, 4'b0000, 4'b0001, 0, 10'd5, 4'd3);
    issue(4'b0000, 4'b0000, 4'b0000);
    issue(4'b0000, 4'b0000, 4'b0000);

    // All request, no lock: rotation starts after requester 0
    addr_v[0] = 10'd10; sel_v[0] = 4'd0;
    addr_v[1] = 10'd20; sel_v[1] = 4'd1;
    addr_v[2] = 10'd30; sel_v[2] = 4'd2;
    addr_v[3] = 10'd40; sel_v[3] = 4'd7;
    for (int i = 0; i < 8; i++) issue(4'b1111, 4'b0000, 4'(1 << ((1 + i) % 4)));

    // Requester 1 locked against requester 2: 20 beats, then 2, then 1 again
    for (int i = 0; i < 20; i++) issue(4'b0110, 4'b0010, 4'b0010);
    issue(4'b0110, 4'b0010, 4'b0100);
    issue(4'b0110, 4'b0010, 4'b0010);
    // Lock dropped after 7 beats with requester 3 pending
    for (int i = 0; i < 6; i++) issue(4'b1010, 4'b0010, 4'b0010);
    issue(4'b1010, 4'b0000, 4'b1000);
    issue(4'b0010, 4'b0000, 4'b0010);
    // Lock without request is ignored
    issue(4'b0000, 4'b0100, 4'b0000);
    issue(4'b0001, 4'b0000, 4'b0001);

    // Address boundaries on requester 0
    issue(4'b0001, 4'b0000, 4'b0001, 0, 10'd399, 4'd3);
    issue(4'b0001, 4'b0000, 4'b0001, 0, 10'd400, 4'd3);
    issue(4'b0001, 4'b0000, 4'b0001, 0, 10'd1023, 4'd9);
    issue(4'b0001, 4'b0000, 4'b0001, 0, 10'd0, 4'd0);
    issue(4'b0000, 4'b0000, 4'b0000);

    // Lone locked requester keeps the ROM every cycle across the burst cap
    for (int i = 0; i < 22; i++) issue(4'b1000, 4'b1000, 4'b1000);
    issue(4'b0000, 4'b0000, 4'b0000);

    // Reset in the cycle after a grant drops the in-flight read
    issue(4'b1111, 4'b0000, 4'b0001);
    issue(4'b1111, 4'b0000, 4'b0010, -1, '0, '0, 1'b0);
    @(negedge i_clk2);
    i_req = 4'b0;
    rq.push_back(rexp_t'{cyc + 1, 4'b0, 8'h00});
    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk2);
    chk("inrst_gnt", 32'(o_gnt), 32'd0);
    chk("inrst_rvalid", 32'(o_rvalid), 32'd0);
    i_rst_n = 1'b1;
    issue(4'b1111, 4'b0000, 4'b0001);
    issue(4'b1111, 4'b0000, 4'b0010);
    repeat (3) issue(4'b0000, 4'b0000, 4'b0000);
    @(negedge i_clk2);
    @(negedge i_clk2);

    chk("drain", 32'(gq.size() + rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
